// File: rtl/capture_arbiter.sv
// rtl/capture_arbiter.sv - merges LPC records, drop markers and heartbeats onto the ring-buffer write port
module capture_arbiter #(
  parameter int DW               = 48,
  parameter int HEARTBEAT_CYCLES = 12000000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] lpc_data,
  input  logic          lpc_enable,
  input  logic          buffer_full,
  output logic [DW-1:0] write_data,
  output logic          write_clock_enable,
  output logic          overflow_flag,
  output logic [15:0]   dropped_count
);

  localparam int CW = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [CW-1:0] HB_LOAD = CW'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);
  localparam bit HB_EN = (HEARTBEAT_CYCLES > 0);

  logic [DW-1:0] hold_data;
  logic          hold_valid;
  logic          marker_pending;
  logic [15:0]   episode_drops;
  logic          hb_pending;
  logic [CW-1:0] hb_count;
  logic [31:0]   hb_seq;

  logic          decide;
  logic          issue_hold;
  logic          issue_bypass;
  logic          issue_marker;
  logic          issue_hb;
  logic          issue_any;
  logic          accept;
  logic          drop;
  logic          hb_expire;
  logic [DW-1:0] marker_record;
  logic [DW-1:0] hb_record;
  logic [DW-1:0] issue_record;
  logic [15:0]   episode_inc;
  logic [15:0]   dropped_inc;

  assign marker_record = {episode_drops, {(DW-20){1'b0}}, 4'hE};
  assign hb_record     = {hb_seq, {(DW-36){1'b0}}, 4'hF};

  // A write strobe blocks the next decision, which caps throughput at one write per two cycles.
  assign decide = !write_clock_enable && !buffer_full;

  // With the hold register empty, a fresh LPC record goes straight out at hold-register priority.
  assign issue_hold   = decide && hold_valid;
  assign issue_bypass = decide && !hold_valid && lpc_enable && !marker_pending;
  assign issue_marker = decide && !hold_valid && marker_pending;
  assign issue_hb     = decide && !hold_valid && !marker_pending && !lpc_enable && hb_pending;
  assign issue_any    = issue_hold || issue_bypass || issue_marker || issue_hb;

  // While a marker is pending every new record is dropped so nothing overtakes the gap.
  assign accept = lpc_enable && !issue_bypass && !marker_pending && (!hold_valid || issue_hold);
  assign drop   = lpc_enable && !issue_bypass && !accept;

  assign episode_inc = (episode_drops == 16'hFFFF) ? 16'hFFFF : episode_drops + 16'd1;
  assign dropped_inc = (dropped_count == 16'hFFFF) ? 16'hFFFF : dropped_count + 16'd1;

  assign hb_expire = HB_EN && (hb_count == '0);

  assign overflow_flag = marker_pending;

  always_comb begin
    issue_record = write_data;
    if (issue_hold) begin
      issue_record = hold_data;
    end else if (issue_bypass) begin
      issue_record = lpc_data;
    end else if (issue_marker) begin
      issue_record = marker_record;
    end else if (issue_hb) begin
      issue_record = hb_record;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_data  <= lpc_data;
      hold_valid <= 1'b1;
    end else if (issue_hold) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      marker_pending <= 1'b0;
      episode_drops  <= '0;
      dropped_count  <= '0;
    end else begin
      if (drop) begin
        marker_pending <= 1'b1;
        dropped_count  <= dropped_inc;
      end else if (issue_marker) begin
        marker_pending <= 1'b0;
      end
      // A drop in the marker's own issue cycle opens a new episode rather than joining the old one.
      if (issue_marker) begin
        episode_drops <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        episode_drops <= episode_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hb_count   <= HB_LOAD;
      hb_pending <= 1'b0;
      hb_seq     <= '0;
    end else begin
      if (HB_EN) begin
        hb_count <= hb_expire ? HB_LOAD : hb_count - 1'b1;
      end
      // Expiry wins over a same-cycle issue; repeated expiries merge into one pending beat.
      if (hb_expire) begin
        hb_pending <= 1'b1;
      end else if (issue_hb) begin
        hb_pending <= 1'b0;
      end
      if (issue_hb) begin
        hb_seq <= hb_seq + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_data         <= '0;
      write_clock_enable <= 1'b0;
    end else begin
      write_data         <= issue_record;
      write_clock_enable <= issue_any;
    end
  end

endmodule
